// File: rtl/mc_seq_ctrl_ws.sv
// Multi-cycle MIPS control sequencer with memory wait states and a registered exception cause.
// Optional memory-timeout watchdog is compiled in with `define SEQ_MEM_TIMEOUT_EN.
module mc_seq_ctrl_ws #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       OF_OUT,
    input  logic       BF_OUT,
    input  logic       MEM_READY,
    output logic       PC_EN,
    output logic [2:0] PC_SEL,
    output logic       IorD,
    output logic       MEM_OE,
    output logic       MEM_WS,
    output logic       IR_EN,
    output logic [1:0] Reg_Dest,
    output logic [2:0] MEMtoREG,
    output logic       REG_WS,
    output logic       SIGNEXT_SEL,
    output logic       ALU_SEL1,
    output logic [2:0] ALU_SEL2,
    output logic [2:0] ALU_OP,
    output logic       PCWrite_BEQ,
    output logic       PCWrite_BNE,
    output logic       EPC_EN,
    output logic       CAUSE_EN,
    output logic [1:0] CAUSE_CODE,
    output logic [3:0] STATE
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_LOAD_WB  = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JUMPR    = 4'd12,
        S_EXC      = 4'd13
    } state_t;

    state_t     state, state_nx;
    logic [1:0] cause_q, cause_nx;
    logic       in_mem;
    logic       timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Memory handshake: a strobe (MEM_OE/MEM_WS) is raised in FETCH, MEM_RD or MEM_WR and held
    // steady; the access completes in the first cycle MEM_READY is high, and MEM_READY is ignored elsewhere.
    assign in_mem = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (RST)
            wait_cnt <= '0;
        else if (in_mem && !MEM_READY)
            wait_cnt <= wait_cnt + CW'(1);
        else
            wait_cnt <= '0;
    end

    // Fires in the last permitted wait cycle, so the access gets exactly TIMEOUT_CYCLES wait cycles.
    assign timeout = in_mem && !MEM_READY && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_FETCH;
            cause_q <= 2'b00;
        end else begin
            state <= state_nx;
            if (state_nx == S_EXC)
                cause_q <= cause_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cause_nx    = cause_q;
        PC_EN       = 1'b0;
        PC_SEL      = 3'b000;
        IorD        = 1'b0;
        MEM_OE      = 1'b0;
        MEM_WS      = 1'b0;
        IR_EN       = 1'b0;
        Reg_Dest    = 2'b00;
        MEMtoREG    = 3'b000;
        REG_WS      = 1'b0;
        SIGNEXT_SEL = 1'b0;
        ALU_SEL1    = 1'b0;
        ALU_SEL2    = 3'b000;
        ALU_OP      = 3'b000;
        PCWrite_BEQ = 1'b0;
        PCWrite_BNE = 1'b0;
        EPC_EN      = 1'b0;
        CAUSE_EN    = 1'b0;
        if (!RST) begin
            case (state)
                S_FETCH: begin
                    MEM_OE   = 1'b1;
                    ALU_SEL2 = 3'b001;
                    IR_EN    = MEM_READY;
                    PC_EN    = MEM_READY;
                    if (MEM_READY)
                        state_nx = S_DECODE;
                    else if (timeout) begin
                        state_nx = S_EXC;
                        cause_nx = 2'b10;
                    end
                end
                S_DECODE: begin
                    ALU_SEL2    = 3'b011;
                    SIGNEXT_SEL = 1'b1;
                    case (Opcode)
                        6'b000000: state_nx = (Funct == 6'b001000) ? S_JUMPR : S_EXEC_R;
                        6'b000010: state_nx = S_JUMP;
                        6'b000100, 6'b000101: state_nx = S_BRANCH;
                        6'b001000, 6'b001001, 6'b001010,
                        6'b001100, 6'b001101, 6'b001110: state_nx = S_EXEC_I;
                        6'b100011, 6'b101011: state_nx = S_MEM_ADDR;
                        default: begin
                            state_nx = S_EXC;
                            cause_nx = 2'b01;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    ALU_SEL1 = 1'b1;
                    ALU_OP   = 3'b010;
                    // Invalid-operation outranks overflow; only the trapping add/sub (Funct[0]==0) overflow.
                    if (BF_OUT) begin
                        state_nx = S_EXC;
                        cause_nx = 2'b01;
                    end else if (OF_OUT && !Funct[0]) begin
                        state_nx = S_EXC;
                        cause_nx = 2'b00;
                    end else
                        state_nx = S_WB_R;
                end
                S_WB_R: begin
                    Reg_Dest = 2'b01;
                    REG_WS   = 1'b1;
                    state_nx = S_FETCH;
                end
                S_EXEC_I: begin
                    ALU_SEL1    = 1'b1;
                    ALU_SEL2    = 3'b010;
                    SIGNEXT_SEL = !Opcode[2];
                    case (Opcode)
                        6'b001010: ALU_OP = 3'b011;
                        6'b001100: ALU_OP = 3'b100;
                        6'b001101: ALU_OP = 3'b101;
                        6'b001110: ALU_OP = 3'b110;
                        default:   ALU_OP = 3'b000;
                    endcase
                    if (OF_OUT && Opcode == 6'b001000) begin
                        state_nx = S_EXC;
                        cause_nx = 2'b00;
                    end else
                        state_nx = S_WB_I;
                end
                S_WB_I: begin
                    REG_WS   = 1'b1;
                    state_nx = S_FETCH;
                end
                S_MEM_ADDR: begin
                    ALU_SEL1    = 1'b1;
                    ALU_SEL2    = 3'b010;
                    SIGNEXT_SEL = 1'b1;
                    state_nx    = Opcode[3] ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    IorD   = 1'b1;
                    MEM_OE = 1'b1;
                    if (MEM_READY)
                        state_nx = S_LOAD_WB;
                    else if (timeout) begin
                        state_nx = S_EXC;
                        cause_nx = 2'b10;
                    end
                end
                S_LOAD_WB: begin
                    MEMtoREG = 3'b001;
                    REG_WS   = 1'b1;
                    state_nx = S_FETCH;
                end
                S_MEM_WR: begin
                    IorD   = 1'b1;
                    MEM_WS = 1'b1;
                    if (MEM_READY)
                        state_nx = S_FETCH;
                    else if (timeout) begin
                        state_nx = S_EXC;
                        cause_nx = 2'b10;
                    end
                end
                S_BRANCH: begin
                    ALU_SEL1    = 1'b1;
                    ALU_OP      = 3'b001;
                    PC_SEL      = 3'b001;
                    PCWrite_BEQ = !Opcode[0];
                    PCWrite_BNE = Opcode[0];
                    state_nx    = S_FETCH;
                end
                S_JUMP: begin
                    PC_EN    = 1'b1;
                    PC_SEL   = 3'b010;
                    state_nx = S_FETCH;
                end
                S_JUMPR: begin
                    PC_EN    = 1'b1;
                    PC_SEL   = 3'b011;
                    state_nx = S_FETCH;
                end
                S_EXC: begin
                    EPC_EN   = 1'b1;
                    CAUSE_EN = 1'b1;
                    PC_EN    = 1'b1;
                    PC_SEL   = 3'b100;
                    state_nx = S_FETCH;
                end
                default: begin
                    state_nx = S_EXC;
                    cause_nx = 2'b01;
                end
            endcase
        end
    end

    assign STATE      = RST ? 4'd0 : state;
    assign CAUSE_CODE = RST ? 2'b00 : cause_q;

endmodule

// File: tb/tb_mc_seq_ctrl_ws.sv
// Directed bench for mc_seq_ctrl_ws: one linear sequence of steps with hand-computed expectations.
// Build with +define+SEQ_MEM_TIMEOUT_EN to exercise the watchdog path (TIMEOUT_CYCLES=4 here).
module tb_mc_seq_ctrl_ws;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] Opcode, Funct;
    logic       OF_OUT, BF_OUT, MEM_READY;
    logic       PC_EN, IorD, MEM_OE, MEM_WS, IR_EN, REG_WS, SIGNEXT_SEL, ALU_SEL1;
    logic [2:0] PC_SEL, MEMtoREG, ALU_SEL2, ALU_OP;
    logic [1:0] Reg_Dest, CAUSE_CODE;
    logic       PCWrite_BEQ, PCWrite_BNE, EPC_EN, CAUSE_EN;
    logic [3:0] STATE;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_s;

    wire [32:0] all_out = {PC_EN, PC_SEL, IorD, MEM_OE, MEM_WS, IR_EN, Reg_Dest, MEMtoREG,
                           REG_WS, SIGNEXT_SEL, ALU_SEL1, ALU_SEL2, ALU_OP, PCWrite_BEQ,
                           PCWrite_BNE, EPC_EN, CAUSE_EN, CAUSE_CODE, STATE};

    mc_seq_ctrl_ws #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .OF_OUT(OF_OUT),
        .BF_OUT(BF_OUT), .MEM_READY(MEM_READY), .PC_EN(PC_EN), .PC_SEL(PC_SEL),
        .IorD(IorD), .MEM_OE(MEM_OE), .MEM_WS(MEM_WS), .IR_EN(IR_EN),
        .Reg_Dest(Reg_Dest), .MEMtoREG(MEMtoREG), .REG_WS(REG_WS),
        .SIGNEXT_SEL(SIGNEXT_SEL), .ALU_SEL1(ALU_SEL1), .ALU_SEL2(ALU_SEL2),
        .ALU_OP(ALU_OP), .PCWrite_BEQ(PCWrite_BEQ), .PCWrite_BNE(PCWrite_BNE),
        .EPC_EN(EPC_EN), .CAUSE_EN(CAUSE_EN), .CAUSE_CODE(CAUSE_CODE), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an instruction in FETCH with memory ready, then advance into DECODE.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn);
        Opcode    = op;
        Funct     = fn;
        MEM_READY = 1'b1;
        #1;
        chk("fetch_state", {29'd0, STATE}, 33'd0);
        cyc();
    endtask

    initial begin
        RST = 1'b1; MEM_READY = 1'b1; Opcode = 6'd0; Funct = 6'b100000;
        OF_OUT = 1'b0; BF_OUT = 1'b0;
        cyc();
        cyc();
        chk("rst_all_zero", all_out, 33'd0);
        RST = 1'b0;
        #1;
        chk("rst_fetch", {29'd0, STATE}, 33'd0);
        chk("rst_fetch_strobes", {30'd0, MEM_OE, IR_EN, PC_EN}, 33'b111);

        // add: FETCH, DECODE, EXEC_R, WB_R
        issue(6'b000000, 6'b100000);
        chk("add_decode", {29'd0, STATE}, 33'd1);
        cyc();
        chk("add_exec", {26'd0, STATE, ALU_OP}, {26'd0, 4'd2, 3'b010});
        cyc();
        chk("add_wb", {26'd0, STATE, REG_WS, Reg_Dest}, {26'd0, 4'd3, 1'b1, 2'b01});
        cyc();
        chk("add_back", {29'd0, STATE}, 33'd0);

        // lw with three wait cycles in MEM_RD: 8 cycles total
        exp_q = '{4'd1, 4'd6, 4'd7, 4'd7, 4'd7, 4'd7, 4'd8, 4'd0};
        issue(6'b100011, 6'd0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            MEM_READY = (i >= 5);
            #1;
            exp_s = exp_q.pop_front();
            chk("lw_state", {29'd0, STATE}, {29'd0, exp_s});
            if (exp_s == 4'd7)
                chk("lw_rd_strobe", {31'd0, MEM_OE, IorD}, 33'b11);
            if (exp_s == 4'd8)
                chk("lw_wb", {29'd0, MEMtoREG, REG_WS}, {29'd0, 3'b001, 1'b1});
        end

        // invalid opcode -> EXC cause 01
        issue(6'b111111, 6'd0);
        cyc();
        chk("inv_exc", {24'd0, STATE, CAUSE_CODE, EPC_EN, CAUSE_EN, PC_EN, PC_SEL},
            {24'd0, 4'd13, 2'b01, 1'b1, 1'b1, 1'b1, 3'b100});
        cyc();
        chk("inv_back_cause_held", {27'd0, STATE, CAUSE_CODE}, {27'd0, 4'd0, 2'b01});

        // beq / bne
        issue(6'b000100, 6'd0);
        cyc();
        chk("beq", {23'd0, STATE, PCWrite_BEQ, PCWrite_BNE, PC_SEL, ALU_OP},
            {23'd0, 4'd10, 1'b1, 1'b0, 3'b001, 3'b001});
        cyc();
        issue(6'b000101, 6'd0);
        cyc();
        chk("bne", {26'd0, STATE, PCWrite_BEQ, PCWrite_BNE, PC_SEL},
            {26'd0, 4'd10, 1'b0, 1'b1, 3'b001});
        cyc();

        // add with overflow -> EXC cause 00, no register write
        issue(6'b000000, 6'b100000);
        OF_OUT = 1'b1;
        cyc();
        chk("addof_exec", {28'd0, STATE, REG_WS}, {28'd0, 4'd2, 1'b0});
        cyc();
        chk("addof_exc", {24'd0, STATE, CAUSE_CODE, EPC_EN, CAUSE_EN, PC_EN, PC_SEL, REG_WS},
            {24'd0, 4'd13, 2'b00, 1'b1, 1'b1, 1'b1, 3'b100, 1'b0});
        OF_OUT = 1'b0;
        cyc();

        // addu ignores overflow
        issue(6'b000000, 6'b100001);
        OF_OUT = 1'b1;
        cyc();
        cyc();
        chk("addu_wb", {28'd0, STATE, REG_WS}, {28'd0, 4'd3, 1'b1});
        OF_OUT = 1'b0;
        cyc();

        // ori: zero-extend, OR op
        issue(6'b001101, 6'd0);
        cyc();
        chk("ori_exec", {22'd0, STATE, SIGNEXT_SEL, ALU_OP, ALU_SEL2, ALU_SEL1},
            {22'd0, 4'd4, 1'b0, 3'b101, 3'b010, 1'b1});
        cyc();
        chk("ori_wb", {26'd0, STATE, Reg_Dest, REG_WS}, {26'd0, 4'd5, 2'b00, 1'b1});
        cyc();

        // addi with overflow -> EXC cause 00
        issue(6'b001000, 6'd0);
        OF_OUT = 1'b1;
        cyc();
        chk("addi_exec", {28'd0, STATE, SIGNEXT_SEL}, {28'd0, 4'd4, 1'b1});
        cyc();
        chk("addi_exc", {27'd0, STATE, CAUSE_CODE}, {27'd0, 4'd13, 2'b00});
        OF_OUT = 1'b0;
        cyc();

        // BF and OF together: BF wins, cause 01
        issue(6'b000000, 6'b100010);
        OF_OUT = 1'b1;
        BF_OUT = 1'b1;
        cyc();
        cyc();
        chk("bf_of_exc", {27'd0, STATE, CAUSE_CODE}, {27'd0, 4'd13, 2'b01});
        OF_OUT = 1'b0;
        BF_OUT = 1'b0;
        cyc();

        // sw, reset asserted during the MEM_WR wait
        issue(6'b101011, 6'd0);
        MEM_READY = 1'b0;
        cyc();
        chk("sw_addr", {29'd0, STATE}, 33'd6);
        cyc();
        chk("sw_wr", {26'd0, STATE, MEM_WS, IorD, MEM_OE}, {26'd0, 4'd9, 3'b110});
        cyc();
        chk("sw_wr_wait", {28'd0, STATE, MEM_WS}, {28'd0, 4'd9, 1'b1});
        RST = 1'b1;
        #1;
        chk("sw_rst_comb_zero", all_out, 33'd0);
        cyc();
        RST = 1'b0;
        #1;
        chk("sw_rst_after", {25'd0, STATE, CAUSE_CODE, MEM_OE, MEM_WS},
            {25'd0, 4'd0, 2'b00, 1'b1, 1'b0});

        // MEM_READY held low in FETCH
`ifdef SEQ_MEM_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("to_wait", {28'd0, STATE, MEM_OE}, {28'd0, 4'd0, 1'b1});
        end
        cyc();
        chk("to_exc", {26'd0, STATE, CAUSE_CODE, MEM_OE}, {26'd0, 4'd13, 2'b10, 1'b0});
        cyc();
`else
        for (int i = 0; i < 100; i++) begin
            cyc();
            chk("fetch_hold", {27'd0, STATE, MEM_OE, IR_EN}, {27'd0, 4'd0, 1'b1, 1'b0});
        end
`endif
        MEM_READY = 1'b1;
        Opcode    = 6'b000010;
        cyc();
        chk("jump_decode", {29'd0, STATE}, 33'd1);
        cyc();
        chk("jump", {25'd0, STATE, PC_EN, PC_SEL}, {25'd0, 4'd11, 1'b1, 3'b010});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_seq_ctrl_ws.md
# mc_seq_ctrl_ws

Next-generation multi-cycle control sequencer for the MIPS datapath. It adds a memory ready handshake with unbounded wait states and a registered exception cause code. It also adds an optional memory-timeout watchdog and fully defaulted outputs, so no output holds a stale value from a previous state. It sits between the Instruction Register (Opcode/Funct), the ALU flags and the datapath muxes, register file, memory, EPC and Cause registers.

## Interface
- TIMEOUT_CYCLES, 16: wait-state limit per memory access (used only with the watchdog compiled in); must be ≥1.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- Opcode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- OF_OUT  in  1  ALU arithmetic overflow.
- BF_OUT  in  1  ALU invalid-operation flag.
- MEM_READY  in  1  memory completes current access this cycle.
- PC_EN  out  1  PC write enable.
- PC_SEL  out  3  PC source: 000 ALU, 001 ALUOut (branch), 010 jump target, 011 rs (JR), 100 exception vector.
- IorD  out  1  memory address: 0 PC, 1 ALUOut.
- MEM_OE, MEM_WS  out  1 each  memory read / write strobes.
- IR_EN  out  1  IR write enable.
- Reg_Dest  out  2  00 rt, 01 rd.
- MEMtoREG  out  3  000 ALUOut, 001 MDR.
- REG_WS  out  1  register file write.
- SIGNEXT_SEL  out  1  1 sign-extend, 0 zero-extend.
- ALU_SEL1  out  1  0 PC, 1 A.
- ALU_SEL2  out  3  000 B, 001 const 4, 010 imm, 011 imm<<2.
- ALU_OP  out  3  000 add, 001 sub, 010 funct, 011 slt, 100 and, 101 or, 110 xor.
- PCWrite_BEQ, PCWrite_BNE  out  1 each  conditional branch enables.
- EPC_EN, CAUSE_EN  out  1 each  EPC / Cause register writes.
- CAUSE_CODE  out  2  00 overflow, 01 invalid instruction/operation, 10 memory timeout.
- STATE  out  4  current state encoding (debug).

## Operation
- All outputs default to 0 in every state; each state drives only the outputs listed below.
- FETCH(0): MEM_OE=1, IorD=0, ALU_SEL2=001, ALU_OP=000, PC_SEL=000. IR_EN=PC_EN=MEM_READY. Go to DECODE on MEM_READY, else stay.
- DECODE(1): ALU_SEL2=011, SIGNEXT_SEL=1, ALU_OP=000. Dispatch on Opcode:
  - 000000: Funct 001000 → JUMPR; any other Funct → EXEC_R.
  - 000010 → JUMP.
  - 000100, 000101 → BRANCH.
  - 001000/001001/001010 → EXEC_I with sign-extend.
  - 001100/001101/001110 → EXEC_I with zero-extend.
  - 100011 → MEM_ADDR (load); 101011 → MEM_ADDR (store).
  - Anything else → EXC with cause 01.
- EXEC_R(2): ALU_SEL1=1, ALU_SEL2=000, ALU_OP=010. BF_OUT → EXC cause 01. Else OF_OUT & Funct[0]==0 (signed add/sub) → EXC cause 00. Else → WB_R.
- WB_R(3): Reg_Dest=01, MEMtoREG=000, REG_WS=1 → FETCH.
- EXEC_I(4): ALU_SEL1=1, ALU_SEL2=010, SIGNEXT_SEL per class. ALU_OP: 000 addi/addiu, 011 slti, 100 andi, 101 ori, 110 xori. OF_OUT on addi (001000) only → EXC cause 00; else → WB_I.
- WB_I(5): Reg_Dest=00, MEMtoREG=000, REG_WS=1 → FETCH.
- MEM_ADDR(6): ALU_SEL1=1, ALU_SEL2=010, SIGNEXT_SEL=1, ALU_OP=000 → MEM_RD (100011) or MEM_WR (101011).
- MEM_RD(7): IorD=1, MEM_OE=1; stay until MEM_READY → LOAD_WB.
- LOAD_WB(8): Reg_Dest=00, MEMtoREG=001, REG_WS=1 → FETCH.
- MEM_WR(9): IorD=1, MEM_WS=1; stay until MEM_READY → FETCH.
- BRANCH(10): ALU_SEL1=1, ALU_SEL2=000, ALU_OP=001, PC_SEL=001, PCWrite_BEQ=~Opcode[0], PCWrite_BNE=Opcode[0] → FETCH.
- JUMP(11): PC_EN=1, PC_SEL=010 → FETCH.
- JUMPR(12): PC_EN=1, PC_SEL=011 → FETCH.
- EXC(13): EPC_EN=1, CAUSE_EN=1, PC_EN=1, PC_SEL=100 → FETCH.
- CAUSE_CODE is a register loaded on each transition into EXC and held otherwise; it is valid throughout EXC.
- Unused encodings 14–15 → EXC with cause 01.

## Timing
- Reset: at a rising edge with RST=1, state becomes FETCH, CAUSE_CODE becomes 00 and the wait counter is cleared. While RST=1, every output is forced to 0 combinationally.
- Latency with zero wait states:
  - R-type / I-type ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch / jump: 3 cycles.
  - Exception: +1 cycle.
- Each cycle of MEM_READY=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle. Strobes stay asserted and stable while waiting.
- MEM_READY is ignored outside FETCH, MEM_RD and MEM_WR.
- If BF_OUT and OF_OUT are both high in EXEC_R, BF_OUT wins (cause 01).
- Branch condition is evaluated by the datapath in the BRANCH cycle; the sequencer does not sample ALU zero.

## Configuration
- SEQ_MEM_TIMEOUT_EN defined:
  - The wait counter increments each waiting cycle and clears on MEM_READY or on leaving a memory state.
  - When the count reaches TIMEOUT_CYCLES with MEM_READY still 0, the next state is EXC with cause 10. Strobes drop in EXC.
  - MEM_READY=1 on the limit cycle completes the access normally.
- Undefined: no counter is built; memory states wait indefinitely and cause 10 is never produced.

## Test plan
- Reset with RST=1 for 2 cycles, MEM_READY=1: all outputs 0 during reset, then STATE=0 with MEM_OE=1. Add (Opcode 000000, Funct 100000, no flags): REG_WS=1, Reg_Dest=01 in cycle 4, then STATE=0.
- LW with MEM_READY low for 3 cycles in MEM_RD: MEM_OE/IorD held for 4 cycles; LOAD_WB asserts MEMtoREG=001, REG_WS=1; total latency 8 cycles.
- Add with OF_OUT=1 in EXEC_R: EXC with CAUSE_CODE=00, EPC_EN=CAUSE_EN=PC_EN=1, PC_SEL=100; REG_WS never asserted. Same stimulus with Funct 100001 (addu) → WB_R.
- Opcode 111111: DECODE → EXC with CAUSE_CODE=01. BEQ (000100): BRANCH asserts PCWrite_BEQ=1, PCWrite_BNE=0, PC_SEL=001.
- With SEQ_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, MEM_READY held 0 in FETCH: EXC after the 4th wait cycle, CAUSE_CODE=10. Without the macro, FETCH holds for 100 cycles.
- Assert RST during MEM_WR wait: next edge STATE=0, CAUSE_CODE=00; MEM_WS drops immediately while RST=1.
